// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute sequencing with
// memory-ready stalls. Inputs Op/Funct/Zero/MemReady; outputs the
// datapath controls, PCEn, ALUControl, Illegal pulse and State code.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  state_t     state_nx;
  logic       pc_write;
  logic       branch;
  logic [2:0] fn_alu;
  logic       fn_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nx;
  end

  assign State = state;
  assign PCEn  = pc_write | (branch & Zero);

  always_comb begin
    fn_alu = ALU_ADD;
    fn_ok  = 1'b1;
    case (Funct)
      6'b100000: fn_alu = ALU_ADD;
      6'b100010: fn_alu = ALU_SUB;
      6'b100100: fn_alu = ALU_AND;
      6'b100101: fn_alu = ALU_OR;
      6'b101010: fn_alu = ALU_SLT;
      default:   fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = MemReady;
        pc_write = MemReady;
        state_nx = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          6'b100011,
          6'b101011: state_nx = MEMADR;
          6'b000000: state_nx = EXECUTE;
          6'b000100: state_nx = BRANCH;
          6'b001000: state_nx = ADDIEX;
          6'b000010: state_nx = JUMP;
          default:   Illegal  = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = (Op == 6'b100011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD     = 1'b1;
        state_nx = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_nx = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
        Illegal    = ~fn_ok;
        state_nx   = fn_ok ? ALUWB : FETCH;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = fn_alu;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_nx = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Testbench for mips_mc_controller: table vectors, corner sequences
// and randomized stimulus against a table-based reference model.
module tb_mips_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] aluc;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          n;
    logic [23:0] seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst;
  logic       MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  int   checks = 0;
  int   errors = 0;
  int   ms;
  ctl_t row [12];
  vec_t vecs [11];

  logic [5:0] ops [6] = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2};
  int         odst [6] = '{2, 2, 6, 8, 9, 11};
  logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  logic [2:0] fal [5] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7};

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
    .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic int oidx(input logic [5:0] op);
    for (int i = 0; i < 6; i++) if (ops[i] == op) return i;
    return -1;
  endfunction

  function automatic int fidx(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (fns[i] == f) return i;
    return -1;
  endfunction

  function automatic int nxt(input int s, input logic [5:0] op,
                             input logic [5:0] f, input logic mr);
    int k;
    case (s)
      0: return mr ? 1 : 0;
      1: begin
        k = oidx(op);
        return (k < 0) ? 0 : odst[k];
      end
      2: return (op == 6'd35) ? 3 : 5;
      3: return mr ? 4 : 3;
      5: return mr ? 0 : 5;
      6: return (fidx(f) < 0) ? 0 : 7;
      9: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic ctl_t expv(input int s, input logic [5:0] op,
                                input logic [5:0] f, input logic mr,
                                input logic z);
    ctl_t e;
    int   k;
    e = row[s];
    e.st = s[3:0];
    k = fidx(f);
    if (s == 0) begin
      e.irwrite = mr;
      e.pcen = mr;
    end
    if (s == 1) e.illegal = (oidx(op) < 0);
    if (s == 6 || s == 7) e.aluc = (k < 0) ? 3'd2 : fal[k];
    if (s == 6) e.illegal = (k < 0);
    if (s == 8) e.pcen = z;
    return e;
  endfunction

  function automatic ctl_t gotv();
    ctl_t g;
    g.st = State;
    g.iord = IorD;
    g.memwrite = MemWrite;
    g.irwrite = IRWrite;
    g.regdst = RegDst;
    g.memtoreg = MemtoReg;
    g.regwrite = RegWrite;
    g.alusrca = ALUSrcA;
    g.alusrcb = ALUSrcB;
    g.pcsrc = PCSrc;
    g.pcen = PCEn;
    g.aluc = ALUControl;
    g.illegal = Illegal;
    return g;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic [5:0] f,
                     input logic mr, input logic z, input logic rn,
                     input string nm);
    Op = op;
    Funct = f;
    MemReady = mr;
    Zero = z;
    reset_n = rn;
    #1;
    chk(nm, gotv(), expv(ms, op, f, mr, z));
    @(posedge clk);
    ms = rn ? nxt(ms, op, f, mr) : 0;
    #1;
  endtask

  task automatic to_exec(input logic [5:0] op, input logic [5:0] f);
    cyc(op, f, 1'b0, 1'b0, 1'b0, "seq_rst");
    cyc(op, f, 1'b1, 1'b0, 1'b1, "seq_fetch");
    cyc(op, f, 1'b1, 1'b0, 1'b1, "seq_decode");
  endtask

  initial begin
    ctl_t e;
    int   mw;
    for (int i = 0; i < 12; i++) begin
      row[i] = '0;
      row[i].aluc = 3'b010;
    end
    row[0].alusrcb = 2'd1;
    row[1].alusrcb = 2'd3;
    row[2].alusrca = 1'b1;
    row[2].alusrcb = 2'd2;
    row[3].iord = 1'b1;
    row[4].memtoreg = 1'b1;
    row[4].regwrite = 1'b1;
    row[5].iord = 1'b1;
    row[5].memwrite = 1'b1;
    row[6].alusrca = 1'b1;
    row[7].regdst = 1'b1;
    row[7].regwrite = 1'b1;
    row[8].alusrca = 1'b1;
    row[8].pcsrc = 2'd1;
    row[8].aluc = 3'b110;
    row[9].alusrca = 1'b1;
    row[9].alusrcb = 2'd2;
    row[10].regwrite = 1'b1;
    row[11].pcsrc = 2'd2;
    row[11].pcen = 1'b1;

    vecs[0]  = '{"lw",     6'd35, 6'd0,  1'b0, 6, 24'h012340};
    vecs[1]  = '{"sw",     6'd43, 6'd0,  1'b0, 5, 24'h012500};
    vecs[2]  = '{"add",    6'd0,  6'd32, 1'b0, 5, 24'h016700};
    vecs[3]  = '{"sub",    6'd0,  6'd34, 1'b0, 5, 24'h016700};
    vecs[4]  = '{"slt",    6'd0,  6'd42, 1'b0, 5, 24'h016700};
    vecs[5]  = '{"beq_z1", 6'd4,  6'd0,  1'b1, 4, 24'h018000};
    vecs[6]  = '{"beq_z0", 6'd4,  6'd0,  1'b0, 4, 24'h018000};
    vecs[7]  = '{"addi",   6'd8,  6'd0,  1'b0, 5, 24'h019a00};
    vecs[8]  = '{"j",      6'd2,  6'd0,  1'b0, 4, 24'h01b000};
    vecs[9]  = '{"bad_op", 6'd63, 6'd0,  1'b0, 3, 24'h010000};
    vecs[10] = '{"bad_fn", 6'd0,  6'd7,  1'b0, 4, 24'h016000};

    Op = '0;
    Funct = '0;
    Zero = 1'b0;
    MemReady = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    ms = 0;

    cyc(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "rst");
    e = '0;
    e.alusrcb = 2'b01;
    e.aluc = 3'b010;
    for (int k = 0; k < 3; k++) begin
      MemReady = 1'b0;
      reset_n = 1'b1;
      #1;
      chk("reset_idle", gotv(), e);
      cyc(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, "reset_wait");
    end

    foreach (vecs[i]) begin
      cyc(vecs[i].op, vecs[i].funct, 1'b1, vecs[i].zero, 1'b0, "v_rst");
      for (int k = 0; k < vecs[i].n; k++) begin
        chk({vecs[i].name, "_state"}, {28'd0, State},
            {28'd0, vecs[i].seq[23-4*k -: 4]});
        cyc(vecs[i].op, vecs[i].funct, 1'b1, vecs[i].zero, 1'b1,
            vecs[i].name);
      end
    end

    to_exec(6'd43, 6'd0);
    cyc(6'd43, 6'd0, 1'b1, 1'b0, 1'b1, "sw_adr");
    mw = 0;
    for (int k = 0; k < 8 && State == 4'd5; k++) begin
      if (MemWrite) mw++;
      cyc(6'd43, 6'd0, (k >= 3), 1'b0, 1'b1, "sw_wait");
    end
    chk("sw_memwrite_cycles", mw, 4);
    chk("sw_end_state", {28'd0, State}, 32'd0);

    to_exec(6'd0, 6'd42);
    #1;
    chk("slt_exec_alu", {29'd0, ALUControl}, 32'd7);
    cyc(6'd0, 6'd42, 1'b1, 1'b0, 1'b1, "slt_exec");
    chk("slt_wb_alu", {29'd0, ALUControl}, 32'd7);
    chk("slt_wb_ctl", {30'd0, RegDst, RegWrite}, 32'd3);
    cyc(6'd0, 6'd42, 1'b1, 1'b0, 1'b1, "slt_wb");

    to_exec(6'd35, 6'd0);
    cyc(6'd35, 6'd0, 1'b1, 1'b0, 1'b1, "lw_adr");
    cyc(6'd35, 6'd0, 1'b0, 1'b0, 1'b1, "lw_stall");
    chk("lw_in_memread", {28'd0, State}, 32'd3);
    cyc(6'd35, 6'd0, 1'b0, 1'b0, 1'b0, "lw_abort");
    chk("lw_abort_state", {28'd0, State}, 32'd0);
    chk("lw_abort_iord", {31'd0, IorD}, 32'd0);

    to_exec(6'd43, 6'd0);
    cyc(6'd43, 6'd0, 1'b1, 1'b0, 1'b1, "sw_adr2");
    cyc(6'd43, 6'd0, 1'b0, 1'b0, 1'b1, "sw_stall2");
    chk("sw_mw_held", {31'd0, MemWrite}, 32'd1);
    cyc(6'd43, 6'd0, 1'b0, 1'b0, 1'b0, "sw_abort");
    chk("sw_abort_mw", {31'd0, MemWrite}, 32'd0);

    cyc(6'd63, 6'd0, 1'b0, 1'b0, 1'b0, "ill_rst");
    cyc(6'd63, 6'd0, 1'b1, 1'b0, 1'b1, "ill_fetch");
    #1;
    chk("ill_pulse", {31'd0, Illegal}, 32'd1);
    cyc(6'd63, 6'd0, 1'b0, 1'b0, 1'b1, "ill_decode");
    chk("ill_cleared", {31'd0, Illegal}, 32'd0);
    chk("ill_to_fetch", {28'd0, State}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      int         r;
      logic [5:0] op;
      logic [5:0] f;
      r = $urandom_range(0, 7);
      op = (r < 6) ? ops[r] : 6'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                      : fns[$urandom_range(0, 4)];
      cyc(op, f, ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 49) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
